// File: rtl/doraemon_pkg.sv
// Shared constants, slot record and FSM state type for the Doraemon candidate picker.
package doraemon_pkg;

  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned SCORE_W   = 13;
  localparam int unsigned ATTR_W    = 8;
  localparam int unsigned ID_W      = 5;
  localparam int unsigned IDX_W     = 3;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ATTR_W-1:0] size;
    logic [ATTR_W-1:0] iq;
    logic [ATTR_W-1:0] eq;
  } slot_t;

  typedef enum logic [1:0] {
    StFill,
    StCalc,
    StOut,
    StRefill
  } state_e;

endpackage

// File: rtl/doraemon_score.sv
// Weighted score of one candidate: size*ws + iq*wi + eq*we, full 13-bit result.
module doraemon_score
  import doraemon_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic [DSIZE-1:0]   size_i,
  input  logic [DSIZE-1:0]   iq_i,
  input  logic [DSIZE-1:0]   eq_i,
  input  logic [2:0]         size_weight_i,
  input  logic [2:0]         iq_weight_i,
  input  logic [2:0]         eq_weight_i,
  output logic [SCORE_W-1:0] score_o
);

  always_comb begin
    score_o = SCORE_W'(size_i) * SCORE_W'(size_weight_i)
            + SCORE_W'(iq_i)   * SCORE_W'(iq_weight_i)
            + SCORE_W'(eq_i)   * SCORE_W'(eq_weight_i);
  end

endmodule

// File: rtl/doraemon_picker.sv
// Five-slot candidate picker: fill, score every slot, emit the best, refill the vacated slot.
module doraemon_picker
  import doraemon_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned IDW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDW-1:0]   doraemon_id,
  input  logic [DSIZE-1:0] size,
  input  logic [DSIZE-1:0] iq_score,
  input  logic [DSIZE-1:0] eq_score,
  input  logic [2:0]       size_weight,
  input  logic [2:0]       iq_weight,
  input  logic [2:0]       eq_weight,
  output logic             ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]       win_idx_q, win_idx_d;
  slot_t                  slots_q [NUM_SLOTS];
  slot_t                  slots_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   empty_q, empty_d;
  logic [SCORE_W-1:0]     score_q [NUM_SLOTS];
  logic [SCORE_W-1:0]     score_d [NUM_SLOTS];
  logic [SCORE_W-1:0]     score_c [NUM_SLOTS];
  logic [2:0]             wsz_q, wsz_d, wiq_q, wiq_d, weq_q, weq_d;
  logic [IDX_W-1:0]       win_c;
  logic [SCORE_W-1:0]     best_c;
  logic                   found_c;
  logic                   accept;
  slot_t                  in_rec;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_score
    doraemon_score #(
      .DSIZE(ATTR_W)
    ) u_score (
      .size_i       (slots_q[g].size),
      .iq_i         (slots_q[g].iq),
      .eq_i         (slots_q[g].eq),
      .size_weight_i(wsz_q),
      .iq_weight_i  (wiq_q),
      .eq_weight_i  (weq_q),
      .score_o      (score_c[g])
    );
  end

  assign ready  = (state_q != StCalc);
  assign accept = in_valid & ready;

  always_comb begin
    in_rec.id   = ID_W'(doraemon_id);
    in_rec.size = ATTR_W'(size);
    in_rec.iq   = ATTR_W'(iq_score);
    in_rec.eq   = ATTR_W'(eq_score);
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    win_c   = '0;
    best_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!empty_q[i] && (!found_c || score_q[i] > best_c)) begin
        found_c = 1'b1;
        best_c  = score_q[i];
        win_c   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    win_idx_d  = win_idx_q;
    slots_d    = slots_q;
    empty_d    = empty_q;
    score_d    = score_q;
    wsz_d      = wsz_q;
    wiq_d      = wiq_q;
    weq_d      = weq_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          slots_d[fill_cnt_q] = in_rec;
          empty_d[fill_cnt_q] = 1'b0;
          if (fill_cnt_q == IDX_W'(NUM_SLOTS - 1)) begin
            fill_cnt_d = '0;
            wsz_d      = size_weight;
            wiq_d      = iq_weight;
            weq_d      = eq_weight;
            state_d    = StCalc;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      StCalc: begin
        score_d = score_c;
        state_d = StOut;
      end
      StOut: begin
        win_idx_d      = win_c;
        empty_d[win_c] = 1'b1;
        // The vacated slot is reusable in the same cycle it is announced.
        if (accept) begin
          slots_d[win_c] = in_rec;
          empty_d[win_c] = 1'b0;
          wsz_d          = size_weight;
          wiq_d          = iq_weight;
          weq_d          = eq_weight;
          state_d        = StCalc;
        end else begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (accept) begin
          slots_d[win_idx_q] = in_rec;
          empty_d[win_idx_q] = 1'b0;
          wsz_d              = size_weight;
          wiq_d              = iq_weight;
          weq_d              = eq_weight;
          state_d            = StCalc;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    out_valid = (state_q == StOut);
    out       = '0;
    if (out_valid) begin
      out = DSIZE'({win_c, slots_q[win_c].id});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      win_idx_q  <= '0;
      slots_q    <= '{default: '0};
      empty_q    <= '1;
      score_q    <= '{default: '0};
      wsz_q      <= '0;
      wiq_q      <= '0;
      weq_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      win_idx_q  <= win_idx_d;
      slots_q    <= slots_d;
      empty_q    <= empty_d;
      score_q    <= score_d;
      wsz_q      <= wsz_d;
      wiq_q      <= wiq_d;
      weq_q      <= weq_d;
    end
  end

endmodule

// File: tb/tb_doraemon_picker.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-array model.
module tb_doraemon_picker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] doraemon_id = '0;
  logic [7:0] size = '0, iq_score = '0, eq_score = '0;
  logic [2:0] size_weight = '0, iq_weight = '0, eq_weight = '0;
  logic       ready, out_valid;
  logic [7:0] out;

  int n_checks = 0;
  int n_errors = 0;

  doraemon_picker #(
    .DSIZE(8),
    .IDW  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .doraemon_id(doraemon_id),
    .size       (size),
    .iq_score   (iq_score),
    .eq_score   (eq_score),
    .size_weight(size_weight),
    .iq_weight  (iq_weight),
    .eq_weight  (eq_weight),
    .ready      (ready),
    .out_valid  (out_valid),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 = accepting without result, 1 = computing, 2 = presenting result.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_win   = 0;
  int m_id[5], m_sz[5], m_iq[5], m_eq[5];

  function automatic int pick(input int ws, input int wi, input int we);
    int bs, bi, s;
    bs = -1;
    bi = 0;
    for (int i = 0; i < 5; i++) begin
      s = m_sz[i] * ws + m_iq[i] * wi + m_eq[i] * we;
      if (s > bs) begin
        bs = s;
        bi = i;
      end
    end
    return bi;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int slot;
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_win   = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (in_valid) begin
      slot = (m_cnt < 5) ? m_cnt : m_win;
      m_id[slot] = int'(doraemon_id);
      m_sz[slot] = int'(size);
      m_iq[slot] = int'(iq_score);
      m_eq[slot] = int'(eq_score);
      if (m_cnt < 5) m_cnt++;
      if (m_cnt == 5) begin
        m_win   = pick(int'(size_weight), int'(iq_weight), int'(eq_weight));
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    int exp_out;
    exp_out = (m_phase == 2) ? ((m_win << 5) | m_id[m_win]) : 0;
    chk("ready", 32'(ready), 32'(m_phase != 1));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    chk("out", 32'(out), 32'(exp_out));
  end

  task automatic drive(input int id, input int sz, input int iq, input int eq,
                       input int ws, input int wi, input int we);
    in_valid    = 1'b1;
    doraemon_id = 5'(id);
    size        = 8'(sz);
    iq_score    = 8'(iq);
    eq_score    = 8'(eq);
    size_weight = 3'(ws);
    iq_weight   = 3'(wi);
    eq_weight   = 3'(we);
  endtask

  task automatic send(input int id, input int sz, input int iq, input int eq,
                      input int ws, input int wi, input int we);
    bit ok;
    ok = 1'b0;
    drive(id, sz, iq, eq, ws, wi, we);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_out", 32'(out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill, then refill the vacated slot during the result cycle (input held through CALC).
    for (int i = 0; i < 5; i++) send(i + 1, (i + 1) * 10, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("fill_calc_ready", 32'(ready), 32'd0);
    chk("fill_calc_valid", 32'(out_valid), 32'd0);
    drive(6, 60, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    chk("fill_out", 32'(out), 32'h85);
    chk("fill_out_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_calc_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("refill_out", 32'(out), 32'h86);
    @(negedge clk);
    chk("refill_idle_valid", 32'(out_valid), 32'd0);

    // Tie: lowest index wins.
    do_reset();
    for (int i = 0; i < 5; i++) send(i + 1, 100, 100, 100, 1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("tie_out", 32'(out), 32'h01);

    // Saturated scores 5355, then refill slot 0 with a slightly lower record.
    do_reset();
    for (int i = 0; i < 5; i++) send(i + 1, 255, 255, 255, 7, 7, 7);
    @(negedge clk);
    drive(9, 254, 255, 255, 7, 7, 7);
    @(negedge clk);
    chk("ovf_out0", 32'(out), 32'h01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ovf_out1", 32'(out), 32'h22);

    // 5355 must beat 1400; a 12-bit wrap would not.
    do_reset();
    send(1, 255, 255, 255, 7, 7, 7);
    send(2, 200, 0, 0, 7, 7, 7);
    for (int i = 2; i < 5; i++) send(i + 1, 100, 0, 0, 7, 7, 7);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_out", 32'(out), 32'h01);

    // Reset after 3 fills restarts from slot 0.
    do_reset();
    for (int i = 0; i < 3; i++) send(20 + i, 200, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_out", 32'(out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(11 + i, i + 1, 0, 0, 1, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    send(15, 5, 0, 0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_out_after", 32'(out), 32'h8F);

    // Random traffic, with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      in_valid    = ($urandom_range(0, 9) < 7);
      doraemon_id = 5'($urandom);
      size        = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      iq_score    = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      eq_score    = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      size_weight = 3'($urandom);
      iq_weight   = 3'($urandom);
      eq_weight   = 3'($urandom);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
